mux_scan_ctrl: RTL and testbench

- Upstream/downstream companion to the 8:1 mux stage.
- Drives the mux select lines s1,s2,s3 through channels 0..7, waits a programmable settle time per channel, then samples the mux output y.
- Packs the 8 samples into one byte and presents it on a valid/ready handshake.
- Sits between the 8:1 mux and any byte-wide consumer; turns eight single-bit inputs into one scanned parallel word.

---
 rtl/mux_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scans an external 8:1 mux. Steps the select lines through channels 0..7,
//   holds each select for SETTLE_CYC cycles, samples y_in for one cycle, and
//   presents the eight samples as one byte on a valid/ready handshake.
//
// Parameters
//   SETTLE_CYC   cycles the select is held before sampling (1..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request one full scan (accepted only when idle)
//   y_in         mux output y
//   s1,s2,s3     mux select, {s1,s2,s3} = current channel
//   busy         high while a scan is in progress or a result is held
//   data_out     scanned byte, bit i = sample taken with select = i
//   data_valid   data_out holds a complete scan
//   data_ready   consumer accepts data_out
//   parity_out   XOR of data_out (only when MUX_SCAN_PARITY_EN is defined)
//
// Build option
//   MUX_SCAN_PARITY_EN  adds the registered parity_out port
module mux_scan_ctrl #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y_in,
   output logic       s1,
   output logic       s2,
   output logic       s3,
   output logic       busy,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic       parity_out
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      HOLD
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t     state, state_nxt;
   logic [2:0] ch, ch_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [6:0] sreg, sreg_nxt;
   logic [7:0] dout_nxt;
   logic       valid_nxt;
   logic       busy_nxt;
`ifdef MUX_SCAN_PARITY_EN
   logic       parity_nxt;
`endif

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ch         <= '0;
         cnt        <= '0;
         sreg       <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         parity_out <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         ch         <= ch_nxt;
         cnt        <= cnt_nxt;
         sreg       <= sreg_nxt;
         data_out   <= dout_nxt;
         data_valid <= valid_nxt;
         busy       <= busy_nxt;
`ifdef MUX_SCAN_PARITY_EN
         parity_out <= parity_nxt;
`endif
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = SETTLE;
         SETTLE:  if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (ch == 3'd7) ? HOLD : SETTLE;
         HOLD:    if (data_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath / output next values
   always_comb begin
      ch_nxt    = ch;
      cnt_nxt   = cnt;
      sreg_nxt  = sreg;
      dout_nxt  = data_out;
      valid_nxt = data_valid;
`ifdef MUX_SCAN_PARITY_EN
      parity_nxt = parity_out;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               ch_nxt  = '0;
               cnt_nxt = '0;
            end
         end
         SETTLE: begin
            cnt_nxt = cnt + 4'd1;
         end
         SAMPLE: begin
            if (ch != 3'd7) begin
               for (int unsigned i = 0; i < 7; i++) begin
                  if (ch == 3'(i)) sreg_nxt[i] = y_in;
               end
               ch_nxt  = ch + 3'd1;
               cnt_nxt = '0;
            end else begin
               // the last sample goes straight to data_out so the byte
               // is published whole in a single edge
               dout_nxt  = {y_in, sreg};
               valid_nxt = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
               parity_nxt = ^{y_in, sreg};
`endif
            end
         end
         HOLD: begin
            if (data_ready) begin
               valid_nxt = 1'b0;
               ch_nxt    = '0;
            end
         end
         default: begin
            ch_nxt  = '0;
            cnt_nxt = '0;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   assign {s1, s2, s3} = ch;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic data_ready = 1'b0;
   logic [7:0] xa = '0;
   logic [7:0] xb = '0;

   logic s1a, s2a, s3a, busy_a, valid_a, y_a;
   logic s1b, s2b, s3b, busy_b, valid_b, y_b;
   logic [7:0] dout_a, dout_b;
`ifdef MUX_SCAN_PARITY_EN
   logic par_a, par_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // external 8:1 muxes
   assign y_a = xa[{s1a, s2a, s3a}];
   assign y_b = xb[{s1b, s2b, s3b}];

   mux_scan_ctrl #(.SETTLE_CYC(2)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_a),
      .s1(s1a), .s2(s2a), .s3(s3a), .busy(busy_a),
      .data_out(dout_a), .data_valid(valid_a), .data_ready(data_ready)
`ifdef MUX_SCAN_PARITY_EN
      , .parity_out(par_a)
`endif
   );

   mux_scan_ctrl #(.SETTLE_CYC(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_b),
      .s1(s1b), .s2(s2b), .s3(s3b), .busy(busy_b),
      .data_out(dout_b), .data_valid(valid_b), .data_ready(data_ready)
`ifdef MUX_SCAN_PARITY_EN
      , .parity_out(par_b)
`endif
   );

   // ---------------- behavioural model ----------------
   // Each scan is modelled by elapsed edges t since acceptance: channel c is
   // selected for t in [c*P, (c+1)*P) and sampled on edge (c+1)*P, P = S+1.
   int unsigned P [2] = '{3, 2};
   logic        m_act  [2];
   logic        m_hold [2];
   int unsigned m_t    [2];
   logic [7:0]  m_acc  [2];
   logic [7:0]  m_data [2];

   function automatic logic samp_next(int i);
      return m_act[i] && !m_hold[i] && (((m_t[i] + 1) % P[i]) == 0);
   endfunction

   function automatic logic [2:0] exp_ch(int i);
      if (!m_act[i]) return 3'd0;
      if (m_hold[i]) return 3'd7;
      return 3'(m_t[i] / P[i]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_hold[i] = 1'b0; m_t[i] = 0;
            m_acc[i] = '0;   m_data[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            logic [7:0] xv;
            int unsigned c;
            xv = (i == 0) ? xa : xb;
            if (!m_act[i]) begin
               if (start) begin
                  m_act[i] = 1'b1; m_t[i] = 0; m_acc[i] = '0;
               end
            end else if (m_hold[i]) begin
               if (data_ready) begin
                  m_act[i] = 1'b0; m_hold[i] = 1'b0;
               end
            end else begin
               if (samp_next(i)) begin
                  c = m_t[i] / P[i];
                  m_acc[i][c] = xv[c];
                  if (c == 7) begin
                     m_hold[i] = 1'b1;
                     m_data[i] = m_acc[i];
                  end
               end
               m_t[i]++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("a.sel",   32'({s1a, s2a, s3a}), 32'(exp_ch(0)));
         check("a.busy",  32'(busy_a),  32'(m_act[0]));
         check("a.valid", 32'(valid_a), 32'(m_hold[0]));
         check("a.data",  32'(dout_a),  32'(m_data[0]));
         check("b.sel",   32'({s1b, s2b, s3b}), 32'(exp_ch(1)));
         check("b.busy",  32'(busy_b),  32'(m_act[1]));
         check("b.valid", 32'(valid_b), 32'(m_hold[1]));
         check("b.data",  32'(dout_b),  32'(m_data[1]));
`ifdef MUX_SCAN_PARITY_EN
         check("a.par", 32'(par_a), 32'(^m_data[0]));
         check("b.par", 32'(par_b), 32'(^m_data[1]));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".sel"},   32'({s1a, s2a, s3a}), 32'd0);
      check({tag, ".busy"},  32'(busy_a),  32'd0);
      check({tag, ".valid"}, 32'(valid_a), 32'd0);
      check({tag, ".data"},  32'(dout_a),  32'h00);
      check({tag, ".bbusy"}, 32'(busy_b),  32'd0);
      check({tag, ".bdata"}, 32'(dout_b),  32'h00);
   endtask

   initial begin
      #1;
      check_reset_vals("por");
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // async reset in the middle of channel 3 settle
      xa = 8'h4D; xb = 8'h7F;
      pulse_start();
      repeat (10) cyc();
      check("mid.sel3", 32'({s1a, s2a, s3a}), 32'd3);
      check("mid.busy", 32'(busy_a), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async");
      rst_n = 1'b1;
      cyc();

      // basic scan, latency 24 edges for A
      pulse_start();
      repeat (23) cyc();
      check("lat.a.before", 32'(valid_a), 32'd0);
      cyc();
      check("lat.a.valid", 32'(valid_a), 32'd1);
      check("lat.a.data",  32'(dout_a),  32'h4D);
`ifdef MUX_SCAN_PARITY_EN
      check("lat.a.par", 32'(par_a), 32'd0);
`endif

      // backpressure
      for (int k = 0; k < 10; k++) begin
         cyc();
         check("bp.valid", 32'(valid_a), 32'd1);
         check("bp.data",  32'(dout_a),  32'h4D);
         check("bp.sel",   32'({s1a, s2a, s3a}), 32'd7);
      end
      data_ready = 1'b1;
      cyc();
      data_ready = 1'b0;
      check("hs.valid", 32'(valid_a), 32'd0);
      check("hs.sel",   32'({s1a, s2a, s3a}), 32'd0);
      check("hs.busy",  32'(busy_a), 32'd0);

      // start while busy and during the handshake
      pulse_start();
      repeat (12) cyc();
      check("sb.ch4", 32'({s1a, s2a, s3a}), 32'd4);
      pulse_start();
      repeat (11) cyc();
      check("sb.valid", 32'(valid_a), 32'd1);
      start = 1'b1; data_ready = 1'b1;
      cyc();
      start = 1'b0; data_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("sb.idle", 32'(busy_a), 32'd0);
         cyc();
      end

      // SETTLE_CYC=1 instance with y toggling outside sample cycles
      xa = 8'h4D;
      pulse_start();
      for (int k = 1; k <= 24; k++) begin
         xb = samp_next(1) ? 8'h7F : 8'($urandom);
         cyc();
         if (k == 15) check("s1.before", 32'(valid_b), 32'd0);
         if (k == 16) begin
            check("s1.valid", 32'(valid_b), 32'd1);
            check("s1.data",  32'(dout_b),  32'h7F);
`ifdef MUX_SCAN_PARITY_EN
            check("s1.par", 32'(par_b), 32'd1);
`endif
         end
      end
      check("s1.a.data", 32'(dout_a), 32'h4D);

      // back-to-back
      data_ready = 1'b1;
      cyc();
      data_ready = 1'b0;
      xa = '0; xb = '0;
      pulse_start();
      for (int k = 1; k <= 24; k++) begin
         cyc();
         if (k < 24) check("b2b.a.hold", 32'(dout_a), 32'h4D);
         if (k < 16) check("b2b.b.hold", 32'(dout_b), 32'h7F);
         if (k == 16) check("b2b.b.new", 32'(dout_b), 32'h00);
         if (k == 24) begin
            check("b2b.a.new",   32'(dout_a),  32'h00);
            check("b2b.a.valid", 32'(valid_a), 32'd1);
         end
      end
      data_ready = 1'b1;
      cyc();
      data_ready = 1'b0;

      // randomized traffic with one mid-run reset
      for (int k = 0; k < 3000; k++) begin
         start      = ($urandom_range(0, 3) == 0);
         data_ready = ($urandom_range(0, 2) == 0);
         xa = 8'($urandom);
         xb = 8'($urandom);
         cyc();
         if (k == 1500) begin
            #2 rst_n = 1'b0;
            #1 check("rnd.rst.busy", 32'(busy_a), 32'd0);
            rst_n = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
